// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT output unscrambler.
//   DEFAULT_WIDTH / DEFAULT_N : default sample width and frame length
//   bank_sel_t                : selects one of the two ping-pong banks
//   bitrev()                  : reverses the low log2n bits of a value
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_N     = 8;

    typedef logic bank_sel_t;

    // Reverse the low log2n bits of value; the upper bits of the result are 0.
    // log2n is always a constant at the call site, so this unrolls to wiring.
    function automatic logic [31:0] bitrev(input logic [31:0] value,
                                           input int unsigned log2n);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(log2n)) begin
                result[5'(int'(log2n) - 1 - i)] = value[5'(i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// -----------------------------------------------------------------------------
// fft_reorder_bank
// One N x WIDTH frame buffer for the output unscrambler.
//   clk               : clock
//   wr0_en/idx/data   : write port 0 (even-pair sample)
//   wr1_en/idx/data   : write port 1 (odd-pair sample)
//   rd_idx / rd_data  : combinational read port
// The two write ports always target distinct entries (the bit-reversed
// indices of 2k and 2k+1 differ), so port 0 priority never matters.
// Storage carries no reset; the frame-full flags in the top gate its use.
// -----------------------------------------------------------------------------
module fft_reorder_bank #(
    parameter int WIDTH = 12,
    parameter int N     = 8
) (
    input  logic                 clk,
    input  logic                 wr0_en,
    input  logic [$clog2(N)-1:0] wr0_idx,
    input  logic [WIDTH-1:0]     wr0_data,
    input  logic                 wr1_en,
    input  logic [$clog2(N)-1:0] wr1_idx,
    input  logic [WIDTH-1:0]     wr1_data,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int LOG2N = $clog2(N);

    logic [WIDTH-1:0] mem_reg [N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr0_en && (wr0_idx == LOG2N'(i))) begin
                mem_reg[i] <= wr0_data;
            end else if (wr1_en && (wr1_idx == LOG2N'(i))) begin
                mem_reg[i] <= wr1_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/fft_output_reorder.sv
// -----------------------------------------------------------------------------
// fft_output_reorder
// Unscrambles the 2-parallel radix-2 FFT output. Each frame arrives as N/2
// line pairs in bit-reversed pair order; it is collected in one of two
// ping-pong banks and then streamed out in natural order X[0]..X[N-1].
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : line pair handshake
//   line1_in, line2_in   : X[bitrev(2k)], X[bitrev(2k+1)] for pair k
//   out_valid/out_ready  : output sample handshake
//   out_data             : natural-order sample (0 when out_valid is low)
//   out_last             : only when FFT_REORDER_LAST_EN is defined; marks
//                          X[N-1] of each frame
// -----------------------------------------------------------------------------
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] line1_in,
    input  logic [width-1:0] line2_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic             out_last
`endif
);

    localparam int LOG2N = $clog2(N);
    localparam int HALF  = N / 2;

    localparam logic [LOG2N-2:0] WR_LAST = (LOG2N-1)'(HALF - 1);
    localparam logic [LOG2N-2:0] WR_ONE  = (LOG2N-1)'(1);
    localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] RD_ONE  = LOG2N'(1);

    logic [1:0]       full_reg, full_next;
    bank_sel_t        wr_bank_reg, wr_bank_next;
    bank_sel_t        rd_bank_reg, rd_bank_next;
    logic [LOG2N-2:0] wr_cnt_reg, wr_cnt_next;
    logic [LOG2N-1:0] rd_idx_reg, rd_idx_next;

    logic             in_accept;
    logic             out_xfer;
    logic [LOG2N-1:0] wr_idx_even;
    logic [LOG2N-1:0] wr_idx_odd;
    logic [width-1:0] bank_rd_data [2];

    // Handshakes depend only on registered flags, so there is no
    // combinational path from in_valid to out_valid or out_ready to in_ready.
    assign in_ready  = !full_reg[wr_bank_reg];
    assign out_valid = full_reg[rd_bank_reg];
    assign in_accept = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Pair k carries natural indices bitrev(2k) and bitrev(2k+1).
    assign wr_idx_even = LOG2N'(bitrev(32'({wr_cnt_reg, 1'b0}), LOG2N));
    assign wr_idx_odd  = LOG2N'(bitrev(32'({wr_cnt_reg, 1'b1}), LOG2N));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_bank
            fft_reorder_bank #(
                .WIDTH(width),
                .N    (N)
            ) u_bank (
                .clk     (clk),
                .wr0_en  (in_accept && (wr_bank_reg == bank_sel_t'(gi))),
                .wr0_idx (wr_idx_even),
                .wr0_data(line1_in),
                .wr1_en  (in_accept && (wr_bank_reg == bank_sel_t'(gi))),
                .wr1_idx (wr_idx_odd),
                .wr1_data(line2_in),
                .rd_idx  (rd_idx_reg),
                .rd_data (bank_rd_data[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_idx_reg  <= '0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            wr_cnt_reg  <= wr_cnt_next;
            rd_idx_reg  <= rd_idx_next;
        end
    end

    // Next state. The write side only sets the flag of the bank it owns and
    // the read side only clears the flag of the bank it owns; they can never
    // be the same bank in one cycle, so both updates simply apply.
    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        wr_cnt_next  = wr_cnt_reg;
        rd_idx_next  = rd_idx_reg;

        if (in_accept) begin
            if (wr_cnt_reg == WR_LAST) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = ~wr_bank_reg;
                wr_cnt_next            = '0;
            end else begin
                wr_cnt_next = wr_cnt_reg + WR_ONE;
            end
        end

        if (out_xfer) begin
            if (rd_idx_reg == RD_LAST) begin
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = ~rd_bank_reg;
                rd_idx_next            = '0;
            end else begin
                rd_idx_next = rd_idx_reg + RD_ONE;
            end
        end
    end

    // Outputs
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = bank_rd_data[rd_bank_reg];
        end
    end

`ifdef FFT_REORDER_LAST_EN
    assign out_last = out_valid && (rd_idx_reg == RD_LAST);
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_output_reorder
// Self-checking bench for fft_output_reorder (N=8, width=12). The reference
// model treats the block as two frame slots: a frame becomes readable once
// all its pairs are in, input stalls while two complete frames wait, and
// samples leave in natural order.
// -----------------------------------------------------------------------------
module tb_fft_output_reorder;

    localparam int W   = 12;
    localparam int NP  = 8;
    localparam int LOG = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] line1_in;
    logic [W-1:0] line2_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef FFT_REORDER_LAST_EN
    logic         out_last;
`endif

    fft_output_reorder #(
        .width(W),
        .N    (NP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .line1_in (line1_in),
        .line2_in (line2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef FFT_REORDER_LAST_EN
        ,
        .out_last (out_last)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [W-1:0] p1_q [$];
    logic [W-1:0] p2_q [$];
    logic [W-1:0] exp_q [$];
    int frames_done    = 0;
    int frames_drained = 0;
    int in_cnt         = 0;
    int rd_cnt         = 0;

    logic [W-1:0] x [NP];

    function automatic int tb_rev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG; b++) begin
            r = r * 2 + ((v >> b) & 1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_frame(input logic [W-1:0] f [NP]);
        for (int k = 0; k < NP / 2; k++) begin
            p1_q.push_back(f[tb_rev(2 * k)]);
            p2_q.push_back(f[tb_rev(2 * k + 1)]);
        end
        for (int i = 0; i < NP; i++) begin
            exp_q.push_back(f[i]);
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < NP; i++) begin
            x[i] = W'($urandom);
        end
        push_frame(x);
    endtask

    // One clock cycle: check outputs against the model, drive inputs,
    // take the edge, then advance the model.
    task automatic step(input bit rst_v, input bit want_valid, input bit ordy, input bit chk);
        bit exp_valid;
        bit exp_ready;
        bit acc;
        bit xfer;
        @(negedge clk);
        exp_valid = (frames_done > frames_drained);
        exp_ready = ((frames_done - frames_drained) < 2);
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_data", 32'(out_data), exp_valid ? 32'(exp_q[0]) : 32'd0);
`ifdef FFT_REORDER_LAST_EN
            check("out_last", 32'(out_last), 32'(exp_valid && (rd_cnt == NP - 1)));
`endif
        end
        rst       = rst_v;
        in_valid  = want_valid && (p1_q.size() > 0) && !rst_v;
        line1_in  = in_valid ? p1_q[0] : W'($urandom);
        line2_in  = in_valid ? p2_q[0] : W'($urandom);
        out_ready = ordy;
        acc       = in_valid && exp_ready;
        xfer      = exp_valid && ordy;
        @(posedge clk);
        if (rst_v) begin
            p1_q.delete();
            p2_q.delete();
            exp_q.delete();
            frames_done    = 0;
            frames_drained = 0;
            in_cnt         = 0;
            rd_cnt         = 0;
        end else begin
            if (acc) begin
                void'(p1_q.pop_front());
                void'(p2_q.pop_front());
                in_cnt++;
                if (in_cnt == NP / 2) begin
                    in_cnt = 0;
                    frames_done++;
                end
            end
            if (xfer) begin
                void'(exp_q.pop_front());
                rd_cnt++;
                if (rd_cnt == NP) begin
                    rd_cnt = 0;
                    frames_drained++;
                end
            end
        end
    endtask

    task automatic drain(input int bound);
        for (int c = 0; c < bound && (p1_q.size() > 0 || exp_q.size() > 0); c++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        line1_in  = '0;
        line2_in  = '0;

        // Reset for two cycles, then verify the idle state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Single frame X[i] = i+1: pairs (1,5),(3,7),(2,6),(4,8)
        for (int i = 0; i < NP; i++) x[i] = W'(i + 1);
        push_frame(x);
        repeat (4 + NP + 2) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("single_left", 32'(exp_q.size()), 32'd0);

        // Back-to-back: three frames, output always ready
        repeat (3) random_frame();
        drain(80);

        // Back-pressure: stall after X[0..2] leave; X[3] must hold
        random_frame();
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        drain(40);

        // Extreme sample values at known positions
        x[0] = 12'h800; x[1] = 12'h7FF; x[2] = 12'h7FF; x[3] = 12'h800;
        x[4] = 12'h000; x[5] = 12'h800; x[6] = 12'hFFF; x[7] = 12'h7FF;
        push_frame(x);
        drain(40);

        // Random valid/ready traffic
        repeat (6) random_frame();
        for (int c = 0; c < 300 && (p1_q.size() > 0 || exp_q.size() > 0); c++) begin
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b1);
        end
        drain(100);

        // Reset in the middle of a drain, then a fresh frame
        random_frame();
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        random_frame();
        drain(40);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Output-side unscrambler for the 2-parallel radix-2 FFT pipeline. It receives the final stage's two output lines, which deliver each frame in bit-reversed pair order. It reassembles every N-point frame in a ping-pong buffer and emits it as a single natural-order stream (X[0]…X[N-1]) with a valid/ready handshake. It is the consumer end of the final-stage line interface and the pipeline's only point of back-pressure.

## Interface
- width, 12, signed sample word width (samples are opaque; passed bit-exact)
- N, 8, frame length in points; power of 2, N ≥ 4; LOG2N derived localparam
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  line pair present this cycle
- in_ready  output  1  block can accept a pair this cycle
- line1_in  input  width  first line sample
- line2_in  input  width  second line sample
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  downstream accepts out_data
- out_data  output  width  natural-order sample

## Operation
- Pair accepted when in_valid && in_ready. Accepted pair k (k = 0..N/2-1 within frame): line1_in = X[bitrev_LOG2N(2k)], line2_in = X[bitrev_LOG2N(2k+1)]; both written into write bank at those natural indices in the same cycle.
- in_valid while in_ready low: ignored, no write, pair counter unchanged.
- Two banks of N registers; per-bank full flag; wr_bank, rd_bank pointers; wr_cnt (0..N/2-1), rd_idx (0..N-1).
- in_ready = !full[wr_bank]. Accepting pair N/2-1: set full[wr_bank], toggle wr_bank, wr_cnt←0.
- out_valid = full[rd_bank]; out_data = bank[rd_bank][rd_idx] when out_valid, else 0.
- Sample transferred when out_valid && out_ready: rd_idx++; at rd_idx = N-1: clear full[rd_bank], toggle rd_bank, rd_idx←0.
- Set of full on one bank and clear on the other in the same edge: both take effect; independent.
- Write into a full bank impossible (in_ready low); read of a non-full bank impossible (out_valid low).
- Reset: both full flags 0, pointers/counters 0 → out_valid=0, out_data=0, in_ready=1 in the cycle after rst sampled high. Partial frames (write or read) discarded; storage contents need not reset.

## Timing
- Latency: last pair of a frame accepted at edge t → out_valid=1 with X[0] in cycle after t (one cycle).
- Output: one sample per cycle while out_ready high; frame drains in N cycles.
- Input: N/2 cycles per frame; with output always ready, in_ready stalls only when both banks are full. Sustained throughput is one pair per 2 cycles on average.
- No combinational path from in_valid to out_valid; out_ready → in_ready path is registered through the full flags.

## Configuration
- FFT_REORDER_LAST_EN defined: extra output port out_last (1 bit), high with out_valid when rd_idx = N-1, reset 0.
- Undefined: no out_last port; behaviour otherwise identical.

## Structure
- Shared package fft_pkg: bitrev function (parameterised by LOG2N), bank-index typedef, default width/N constants.
- One sub-module fft_reorder_bank: N×width register array, two write ports (index + data + enable), one combinational read port; instantiated twice.

## Test plan
- Reset: assert rst 2 cycles → out_valid=0, out_data=0, in_ready=1; out_last=0 if enabled.
- Single frame, N=8, X[i]=i+1: pairs (1,5),(3,7),(2,6),(4,8) on consecutive cycles, out_ready=1 → out_data 1,2,…,8 on 8 consecutive cycles, starting the cycle after the 4th pair is accepted; out_last only on the 8.
- Back-to-back: in_valid held high for 3 frames, out_ready=1 → in_ready drops after frame 2 fills and rises when frame 1 finishes draining; 24 outputs in order, none lost or duplicated.
- Back-pressure: out_ready low 3 cycles after X[2] accepted → out_data holds X[3], rd_idx unchanged, resumes with X[3] then X[4].
- Extremes: samples -2048 and 2047 (width=12) → emitted bit-exact at the correct natural indices.
- Reset mid-drain: rst after 3 outputs → next cycle out_valid=0; a fresh frame then produces X[0] first with no stale data.
